alu_exec_stage: RTL and testbench

//  Execute stage downstream of the ALU-control decoder: consumes the 4-bit ALU control

---
 rtl/alu_ctrl_pkg.sv | 20 ++
 rtl/alu_shift_seq.sv | 47 ++++
 rtl/alu_exec_stage.sv | 127 ++++++++++++
 tb/tb_alu_exec_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings and execute-stage FSM states.
// Used by the ALU-control decoder and by alu_exec_stage.
package alu_ctrl_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative 1-bit-per-cycle logical shifter for the execute stage.
// Only present in builds with ALU_SHIFT_EN defined.
// done and value are decoded from internal registers only: done is high in the
// cycle the count goes 1->0, value is the work register after this cycle's shift.
`ifdef ALU_SHIFT_EN
module alu_shift_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic [XLEN-1:0]    value_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [XLEN-1:0]    value
);

  logic [XLEN-1:0]    work;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_q;

  // One-bit shift of the work register; dir=1 shifts right (SRL)
  assign value = dir_q ? (work >> 1) : (work << 1);
  assign done  = (cnt == SHAMT_W'(1));

  // Load on start, then shift once per cycle until the count drains
  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (start) begin
      work  <= value_in;
      cnt   <= shamt;
      dir_q <= dir;
    end else if (cnt != '0) begin
      work  <= value;
      cnt   <= cnt - SHAMT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/alu_exec_stage.sv
// ALU execute stage: valid/ready in, registered result + zero flag out.
// AND/OR/ADD/SUB complete in one cycle; unknown codes give result 0.
// Build option ALU_SHIFT_EN adds SLL/SRL through the iterative shifter
// (latency shamt+1); without it those codes behave as unknown codes.
module alu_exec_stage
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
`ifdef ALU_SHIFT_EN
  , parameter int unsigned SHAMT_W = $clog2(XLEN)
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic                  zero
);

  alu_state_e      state, state_n;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result_n;
  logic            zero_n;
  logic            out_valid_n;
  logic            accept;
  logic            load_shift;

  // A held result frees the stage in the same cycle it is taken downstream
  assign in_ready = (state == IDLE) | ((state == HOLD) & out_ready);
  assign accept   = in_valid & in_ready;

  // Single-cycle operations
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
`ifdef ALU_SHIFT_EN
      ALU_SLL, ALU_SRL: alu_res = op_a;  // shamt==0 only; nonzero goes to SHIFT
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SHIFT_EN
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               shift_done;
  logic [XLEN-1:0]    shift_value;

  assign shamt      = op_b[SHAMT_W-1:0];
  assign is_shift   = (alu_ctrl == ALU_SLL) | (alu_ctrl == ALU_SRL);
  assign load_shift = accept & is_shift & (shamt != '0);

  alu_shift_seq #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .start    (load_shift),
    .dir      (alu_ctrl == ALU_SRL),
    .value_in (op_a),
    .shamt    (shamt),
    .done     (shift_done),
    .value    (shift_value)
  );
`else
  assign load_shift = 1'b0;
`endif

  // Next state and next output-register values
  always_comb begin
    state_n  = state;
    result_n = result;
    case (state)
      IDLE, HOLD: begin
        if ((state == HOLD) && out_ready) begin
          state_n = IDLE;
        end
        if (accept) begin
          if (load_shift) begin
            state_n = SHIFT;
          end else begin
            state_n  = HOLD;
            result_n = alu_res;
          end
        end
      end
`ifdef ALU_SHIFT_EN
      SHIFT: begin
        if (shift_done) begin
          state_n  = HOLD;
          result_n = shift_value;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    zero_n      = ~|result_n;
    out_valid_n = (state_n == HOLD);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      result    <= result_n;
      zero      <= zero_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: vector table plus hand-written sequences, with a
// scoreboard queue filled on accept and drained when results are taken.
// Shift checks are enabled when ALU_SHIFT_EN is defined.
module tb_alu_exec_stage;
  import alu_ctrl_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alu_ctrl = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            zero;

  typedef struct packed {
    logic [XLEN-1:0] r;
    logic            z;
  } exp_t;

  typedef struct {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] r;
    logic            z;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  alu_exec_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (c)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      default: r = '0;
    endcase
    return '{r: r, z: (r == '0)};
  endfunction

  // Scoreboard: compare every result taken downstream against the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got result 0x%0h, expected no output", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_result", result, mon_e.r);
        check("sb_zero", XLEN'(zero), XLEN'(mon_e.z));
      end
    end
  end

  // Present one operation and hold it until accepted (bounded wait)
  task automatic send(input logic [3:0] c, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input exp_t e);
    bit ok = 1'b0;
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

`ifdef ALU_SHIFT_EN
  // Shift op: in_ready low while iterating, out_valid at the required latency
  task automatic shift_latency(input string name, input logic [3:0] c,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [XLEN-1:0] r, input int lat_req);
    int lat = 1;
    send(c, a, b, '{r: r, z: (r == '0)});
    while (!out_valid && lat < 100) begin
      check({name, "_in_ready"}, XLEN'(in_ready), '0);
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, XLEN'(lat), XLEN'(lat_req));
    check({name, "_result"}, result, r);
  endtask
`endif

  vec_t vecs[12];
  logic [3:0] rand_codes[7];
  bit rand_done;

  initial begin
    vecs[0]  = '{ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1};
    vecs[1]  = '{ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0};
    vecs[2]  = '{ALU_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{ALU_SUB, 32'd100, 32'd58, 32'd42, 1'b0};
    vecs[4]  = '{ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0};
    vecs[5]  = '{ALU_OR, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[6]  = '{ALU_OR, 32'h1234_5678, 32'h8765_4321, 32'h9775_5779, 1'b0};
    vecs[7]  = '{4'b0111, 32'hDEAD_BEEF, 32'h1, 32'h0, 1'b1};
    vecs[8]  = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1};
`ifdef ALU_SHIFT_EN
    vecs[9]  = '{ALU_SLL, 32'h1, 32'h4, 32'h10, 1'b0};
    vecs[10] = '{ALU_SRL, 32'h8000_0000, 32'd31, 32'h1, 1'b0};
    vecs[11] = '{ALU_SLL, 32'h0000_ABCD, 32'h20, 32'h0000_ABCD, 1'b0};
`else
    vecs[9]  = '{ALU_SLL, 32'h1, 32'h4, 32'h0, 1'b1};
    vecs[10] = '{ALU_SRL, 32'h8000_0000, 32'd31, 32'h0, 1'b1};
    vecs[11] = '{ALU_SLL, 32'h0000_ABCD, 32'h20, 32'h0, 1'b1};
`endif
    rand_codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1111};

    // Reset held for 2 cycles
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", XLEN'(out_valid), '0);
    check("rst_result", result, '0);
    check("rst_zero", XLEN'(zero), '0);
    check("rst_in_ready", XLEN'(in_ready), XLEN'(1));

    // add 5+7, latency 1
    out_ready = 1'b1;
    send(ALU_ADD, 32'd5, 32'd7, '{r: 32'd12, z: 1'b0});
    check("add_out_valid", XLEN'(out_valid), XLEN'(1));
    check("add_result", result, 32'd12);
    check("add_zero", XLEN'(zero), '0);

    // sub 9-9 then AND back-to-back
    send(ALU_SUB, 32'd9, 32'd9, '{r: 32'd0, z: 1'b1});
    check("b2b_sub_zero", XLEN'(zero), XLEN'(1));
    check("b2b_in_ready", XLEN'(in_ready), XLEN'(1));
    send(ALU_AND, 32'hF0, 32'h0F, '{r: 32'd0, z: 1'b1});
    check("b2b_and_valid", XLEN'(out_valid), XLEN'(1));
    check("b2b_and_zero", XLEN'(zero), XLEN'(1));
    @(posedge clk);
    #1;

    // OR held under backpressure; pending input not accepted
    out_ready = 1'b0;
    send(ALU_OR, 32'hA0, 32'h05, '{r: 32'hA5, z: 1'b0});
    in_valid = 1'b1;
    alu_ctrl = ALU_ADD;
    op_a     = 32'd1;
    op_b     = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", XLEN'(out_valid), XLEN'(1));
      check("bp_result", result, 32'hA5);
      check("bp_in_ready", XLEN'(in_ready), '0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(ALU_ADD, 32'd1, 32'd1, '{r: 32'd2, z: 1'b0});

    // Vector table
    foreach (vecs[i]) begin
      send(vecs[i].ctrl, vecs[i].a, vecs[i].b, '{r: vecs[i].r, z: vecs[i].z});
    end

    // Random operations with random downstream backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [3:0]      c;
          logic [XLEN-1:0] a;
          logic [XLEN-1:0] b;
          c = rand_codes[$urandom_range(0, 6)];
          a = (i % 4 == 0) ? XLEN'(i) : $urandom;
          b = (i % 4 == 0) ? XLEN'(i) : $urandom;
          send(c, a, b, model(c, a, b));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

`ifdef ALU_SHIFT_EN
    shift_latency("sll4", ALU_SLL, 32'h1, 32'h4, 32'h10, 5);
    shift_latency("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 32'h1, 32);
    @(posedge clk);
    #1;
    // Reset in the middle of a long shift
    send(ALU_SLL, 32'h1, 32'd20, '{r: 32'h0010_0000, z: 1'b0});
    repeat (4) @(posedge clk);
    #1;
`else
    // Reset while a result is held
    out_ready = 1'b0;
    send(ALU_SLL, 32'h1, 32'd20, '{r: 32'h0, z: 1'b1});
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    check("midrst_out_valid", XLEN'(out_valid), '0);
    check("midrst_result", result, '0);
    check("midrst_zero", XLEN'(zero), '0);
    check("midrst_in_ready", XLEN'(in_ready), XLEN'(1));
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("midrst_no_output", XLEN'(out_valid), '0);
    end

    // Scoreboard fully drained
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", XLEN'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
